// File: rtl/titan_wb_arbiter.sv
// Two-requester writeback arbiter driving the register-file write port, plus a destination-register busy scoreboard.
// Optional macro TITAN_WB_ARB_RR_EN selects round-robin conflict resolution; otherwise req0 has fixed priority.
module titan_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [(1<<ADDR_W)-1:0] busy_mask,
  output logic [ADDR_W:0]     pending_cnt
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  function automatic logic [CNT_W-1:0] popcount(input logic [NREG-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  logic              prefer1;
  logic              gnt0, gnt1;
  logic              acc0, acc1, acc;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q;

`ifdef TITAN_WB_ARB_RR_EN
  logic rr_q, rr_d;

  // rr_q=1 means req1 is favoured at the next conflict.
  assign prefer1 = rr_q;

  always_comb begin
    rr_d = rr_q;
    if (acc0)      rr_d = 1'b1;
    else if (acc1) rr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`else
  assign prefer1 = 1'b0;
`endif

  // Grant depends only on the valids and the preference, never on the other ready.
  always_comb begin
    gnt0 = req0_valid & ~(req1_valid & prefer1);
    gnt1 = req1_valid & ~(req0_valid & ~prefer1);
  end

  assign req0_ready = gnt0 & ~rst;
  assign req1_ready = gnt1 & ~rst;

  assign acc0     = req0_valid & req0_ready;
  assign acc1     = req1_valid & req1_ready;
  assign acc      = acc0 | acc1;
  assign acc_addr = acc1 ? req1_addr : req0_addr;
  assign acc_data = acc1 ? req1_data : req0_data;

  // Commit clears first so a same-cycle reservation of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[waddr_q] = 1'b0;
    if (rsv_valid && (rsv_addr != '0)) busy_d[rsv_addr] = 1'b1;
  end

  // Writeback stage boundary: accepted write appears on the RF port one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
      cnt_q   <= '0;
    end else begin
      we_q <= acc & (acc_addr != '0);
      if (acc) begin
        waddr_q <= acc_addr;
        wdata_q <= acc_data;
      end
      busy_q <= busy_d;
      cnt_q  <= popcount(busy_d);
    end
  end

  assign rf_we       = we_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign busy_mask   = busy_q;
  assign pending_cnt = cnt_q;

  assign rs1_busy = (rs1_addr != '0) & busy_q[rs1_addr];
  assign rs2_busy = (rs2_addr != '0) & busy_q[rs2_addr];

endmodule

// File: doc/titan_wb_arbiter.md
TITAN_WB_ARBITER -- requirements
Module: titan_wb_arbiter

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, the only clock; rst in 1, asynchronous active-high reset.
REQ-002 SHALL have req0_valid in 1, req0_ready out 1, req0_addr in 5, req0_data in 32: ALU writeback requester.
REQ-003 SHALL have req1_valid in 1, req1_ready out 1, req1_addr in 5, req1_data in 32: load-unit writeback requester.
REQ-004 SHALL have rf_we out 1, rf_waddr out 5, rf_wdata out 32: drive the register file write port.
REQ-005 SHALL have rsv_valid in 1, rsv_addr in 5: decode reserves a destination register.
REQ-006 SHALL have rs1_addr in 5, rs2_addr in 5, rs1_busy out 1, rs2_busy out 1: source hazard query.
REQ-007 SHALL have busy_mask out 32 and pending_cnt out 6: scoreboard state.

Function
REQ-008 SHALL accept at most one request per cycle; request N accepted when reqN_valid and reqN_ready are both high at a clk rising edge.
REQ-009 SHALL drive reqN_ready combinationally high only for the granted requester; ready SHALL NOT depend on the other requester's ready.
REQ-010 SHALL grant the sole valid requester when only one is valid; with neither valid, both readies SHALL be low.
REQ-011 SHALL register an accepted write and present it on rf_waddr/rf_wdata with rf_we high exactly 1 cycle after acceptance, for exactly 1 cycle.
REQ-012 SHALL hold rf_we low in any cycle following no acceptance; rf_waddr/rf_wdata SHALL hold their last values.
REQ-013 SHALL accept a write to address 0 normally but keep rf_we low for it.
REQ-014 SHALL set busy_mask[a] at the edge where rsv_valid=1 and rsv_addr=a, a!=0; reservations of x0 SHALL be ignored.
REQ-015 SHALL clear busy_mask[a] at the edge where rf_we=1 and rf_waddr=a.
REQ-016 SHALL leave the bit set when a reservation and a commit hit the same address in the same cycle; the reservation wins.
REQ-017 SHALL keep pending_cnt equal to the popcount of busy_mask; it SHALL be updated with the mask and never wrap (max 31).
REQ-018 SHALL drive rsN_busy = busy_mask[rsN_addr] combinationally; it SHALL be 0 for address 0.
REQ-019 SHALL report rsN_busy=1 in the commit cycle (rf_we high for that address) and clear it the following cycle; no forwarding.
REQ-020 SHALL let a losing requester stall while holding valid; the arbiter SHALL NOT drop or reorder a held request.

Reset
REQ-021 SHALL on rst asynchronously force rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, pending_cnt=0, and the round-robin pointer to favour req0.
REQ-022 SHALL hold both readies low while rst is high; a write accepted the cycle before rst assertion SHALL be discarded.

Configuration
REQ-023 SHALL support macro TITAN_WB_ARB_RR_EN.
- Defined: round-robin; on a conflict, grant the requester not granted at the last conflict-free-or-conflict acceptance; the pointer updates only on acceptance.
- Undefined: fixed priority, req0 always wins a conflict; no pointer register.

Verification
REQ-024 Reset: assert rst mid-transfer -> rf_we=0, busy_mask=0, pending_cnt=0, both readies low the same cycle.
REQ-025 Single write: req0 addr=5 data=0xDEADBEEF at cycle T -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at T+1; rf_we=0 at T+2.
REQ-026 Conflict: both valid (req0 addr=3, req1 addr=4) for 2 cycles -> RR: req0 then req1 committed on consecutive cycles; fixed: req0 granted until it drops valid.
REQ-027 Scoreboard: rsv addr=7; rs1_addr=7 -> rs1_busy=1, pending_cnt=1; commit of addr 7 -> busy cleared next cycle, pending_cnt=0.
REQ-028 Same-cycle reserve and commit of addr 9 -> busy_mask[9] stays 1, pending_cnt unchanged.
REQ-029 x0 handling: rsv addr=0 and req1 write addr=0 data=0x1 -> busy_mask=0, rf_we never asserted, req1_ready handshake still completes.
